// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one fabric SRAM port between two requesters:
//     req 0 = AHB-Lite SRAM interface, req 1 = bootloader/UART loader path.
//   Round-robin grant when idle. A beat with req_lock=1 keeps ownership for
//   that requester until it sends a beat with req_lock=0. All mem_* outputs
//   are registered. Read data returns two cycles after accept and is tagged
//   with the issuing requester.
//
// Optional feature (macro SRAM_ARB_LOCK_TIMEOUT_EN):
//   A lock owner that presents no request for LOCK_TIMEOUT consecutive cycles
//   loses ownership and sets the sticky lock_err flag (cleared by reset only).
//   Without the macro a lock is held indefinitely and lock_err is tied 0.
//
// Ports
//   HCLK, HRESETN            clock, async active-low reset
//   req_valid/write/lock [2] per-requester request controls
//   req_addr   [2*AW]        word address, req 0 in low AW bits
//   req_byteen [8]           byte enables, req 0 in [3:0]
//   req_wdata  [64]          write data,   req 0 in [31:0]
//   req_gnt    [2]           combinational one-hot/zero grant
//   rsp_rvalid [2]           one-hot read-data-valid pulse
//   rsp_rdata  [32]          read data (mem_rdata passthrough)
//   mem_*                    registered SRAM port; mem_rdata is 1-cycle latency
//   busy                     owned state or a beat on the mem port
//   lock_err                 sticky lock-timeout flag
// ---------------------------------------------------------------------------

// Per-requester grant / response-steering slice.
module sram_arb_lane (
  input  logic valid_i,        // this requester asks
  input  logic other_valid_i,  // the other requester asks
  input  logic own_self_i,     // this requester holds the lock
  input  logic own_other_i,    // the other requester holds the lock
  input  logic prio_i,         // this requester wins a tie
  input  logic rsp_vld_i,      // read data returning this cycle
  input  logic rsp_id_i,       // returning read belongs to this requester
  output logic gnt_o,
  output logic rvalid_o
);
  assign gnt_o    = valid_i & ~own_other_i & (own_self_i | ~other_valid_i | prio_i);
  assign rvalid_o = rsp_vld_i & rsp_id_i;
endmodule

module sram_port_arbiter #(
  parameter  int MEM_DEPTH    = 65536,
  parameter  int LOCK_TIMEOUT = 64,
  localparam int MEM_AWIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic                    HCLK,
  input  logic                    HRESETN,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [1:0]              req_lock,
  input  logic [2*MEM_AWIDTH-1:0] req_addr,
  input  logic [7:0]              req_byteen,
  input  logic [63:0]             req_wdata,
  output logic [1:0]              req_gnt,
  output logic [1:0]              rsp_rvalid,
  output logic [31:0]             rsp_rdata,
  input  logic [31:0]             mem_rdata,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [MEM_AWIDTH-1:0]   mem_addr,
  output logic [3:0]              mem_byteen,
  output logic [31:0]             mem_wdata,
  output logic                    busy,
  output logic                    lock_err
);

  localparam int NUM_REQ   = 2;
  localparam int RD_STAGES = 2;  // accept -> mem port -> read data

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  typedef struct packed {
    logic                  write;
    logic                  lock;
    logic [MEM_AWIDTH-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
  } req_t;

  state_e                state_q, state_d;
  logic                  last_q, last_d;   // index of the last accepted requester
  req_t [NUM_REQ-1:0]    req;
  req_t                  cur;
  logic                  acc, sel;

  // Read tag pipe: stage 1 doubles as mem_ren, stage 2 is the response cycle.
  logic [RD_STAGES:1]    rd_vld_pipe;
  logic [RD_STAGES:1]    rd_id_pipe;

  logic                  mem_wen_q;
  logic [MEM_AWIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_byteen_q;
  logic [31:0]           mem_wdata_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req[i] = {req_write[i], req_lock[i],
                     req_addr[i*MEM_AWIDTH +: MEM_AWIDTH],
                     req_byteen[4*i +: 4], req_wdata[32*i +: 32]};

    sram_arb_lane u_lane (
      .valid_i       (req_valid[i]),
      .other_valid_i (req_valid[NUM_REQ-1-i]),
      .own_self_i    (state_q == ((i == 0) ? OWN0 : OWN1)),
      .own_other_i   (state_q == ((i == 0) ? OWN1 : OWN0)),
      .prio_i        (last_q != 1'(i)),
      .rsp_vld_i     (rd_vld_pipe[RD_STAGES]),
      .rsp_id_i      (rd_id_pipe[RD_STAGES] == 1'(i)),
      .gnt_o         (req_gnt[i]),
      .rvalid_o      (rsp_rvalid[i])
    );
  end

  assign acc = |(req_valid & req_gnt);
  assign sel = req_gnt[1];
  assign cur = req[sel];

`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_err_q;
  logic             owner_idle, tmo_hit;

  // Counts owner-absent cycles; the last one before LOCK_TIMEOUT breaks the lock.
  assign owner_idle = ((state_q == OWN0) & ~req_valid[0]) |
                      ((state_q == OWN1) & ~req_valid[1]);
  assign tmo_hit    = owner_idle & (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (acc || tmo_hit) cnt_d = '0;
    else if (owner_idle) cnt_d = cnt_q + 1'b1;
  end

  assign lock_err = lock_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (LOCK_TIMEOUT > 0);
  assign lock_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (acc) begin
      last_d  = sel;
      state_d = cur.lock ? (sel ? OWN1 : OWN0) : IDLE;
    end
`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
    else if (tmo_hit) begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;   // req 0 wins the first tie
      rd_vld_pipe  <= '0;
      rd_id_pipe   <= '0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wdata_q  <= '0;
`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
      cnt_q        <= '0;
      lock_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rd_vld_pipe <= {rd_vld_pipe[RD_STAGES-1:1], acc & ~cur.write};
      rd_id_pipe  <= {rd_id_pipe[RD_STAGES-1:1], sel};
      mem_wen_q   <= acc & cur.write;
      if (acc) begin
        mem_addr_q   <= cur.addr;
        mem_byteen_q <= cur.write ? cur.be : 4'hF;
        mem_wdata_q  <= cur.wdata;
      end
`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_q | tmo_hit;
`endif
    end
  end

  assign mem_ren    = rd_vld_pipe[1];
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_rdata  = mem_rdata;
  assign busy       = (state_q != IDLE) | mem_ren | mem_wen_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: an SRAM device model on the mem port, a
// transaction-level reference (owner, last winner, reference memory, queue
// of pending responses) checked every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_sram_port_arbiter;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int TMO   = 64;

  logic          HCLK = 1'b0;
  logic          HRESETN = 1'b0;
  logic [1:0]    req_valid, req_write, req_lock;
  logic [2*AW-1:0] req_addr;
  logic [7:0]    req_byteen;
  logic [63:0]   req_wdata;
  logic [1:0]    req_gnt, rsp_rvalid;
  logic [31:0]   rsp_rdata, mem_rdata;
  logic          mem_ren, mem_wen, busy, lock_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_byteen;
  logic [31:0]   mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  sram_port_arbiter #(.MEM_DEPTH(DEPTH), .LOCK_TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_rvalid(rsp_rvalid), .rsp_rdata(rsp_rdata),
    .mem_rdata(mem_rdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .busy(busy), .lock_err(lock_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    merge = o;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = n[8*b +: 8];
  endfunction

  // SRAM device: synchronous, 1-cycle read latency, byte-enabled writes.
  logic [31:0] sram [0:DEPTH-1];
  always @(posedge HCLK) begin
    if (mem_wen) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_byteen);
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  // Reference model.
  logic [31:0]   ref_mem [0:DEPTH-1];
  int            m_owner, m_cnt;
  logic          m_last, m_err;
  logic          e_ren, e_wen;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_be;
  logic [31:0]   e_wd;
  logic          r1_v, r1_id, r2_v, r2_id;
  logic [31:0]   r1_d, r2_d;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin sram[i] = 32'h0; ref_mem[i] = 32'h0; end
  end

  always @(negedge HCLK) begin : model
    logic [1:0]    eg;
    int            id;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
    if (!HRESETN) begin
      m_owner = -1; m_cnt = 0; m_last = 1'b1; m_err = 1'b0;
      e_ren = 0; e_wen = 0; r1_v = 0; r2_v = 0; r1_id = 0; r2_id = 0;
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_rvalid", rsp_rvalid, 0);
      chk("rst_lock_err", lock_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
    end else begin
      if (m_owner >= 0)           eg = req_valid & (2'b01 << m_owner);
      else if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
      else                        eg = req_valid;
      chk("m_gnt", req_gnt, eg);
      chk("m_mem_ren", mem_ren, e_ren);
      chk("m_mem_wen", mem_wen, e_wen);
      if (e_ren || e_wen) begin
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_byteen", mem_byteen, e_be);
      end
      if (e_wen) chk("m_mem_wdata", mem_wdata, e_wd);
      chk("m_rvalid", rsp_rvalid, r2_v ? (r2_id ? 2 : 1) : 0);
      if (r2_v) chk("m_rdata", rsp_rdata, r2_d);
      chk("m_lock_err", lock_err, m_err);
      chk("m_busy", busy, ((m_owner >= 0) || e_ren || e_wen) ? 1 : 0);

      r2_v = r1_v; r2_id = r1_id; r2_d = r1_d;
      r1_v = 0; e_ren = 0; e_wen = 0;
      if (eg != 2'b00) begin
        id = eg[1] ? 1 : 0;
        a  = req_addr[id*AW +: AW];
        be = req_byteen[4*id +: 4];
        wd = req_wdata[32*id +: 32];
        e_addr = a;
        if (req_write[id]) begin
          e_wen = 1; e_be = be; e_wd = wd;
          ref_mem[a] = merge(ref_mem[a], wd, be);
        end else begin
          e_ren = 1; e_be = 4'hF;
          r1_v = 1; r1_id = id[0]; r1_d = ref_mem[a];
        end
        m_last  = id[0];
        m_cnt   = 0;
        m_owner = req_lock[id] ? id : -1;
      end else if (m_owner >= 0 && !req_valid[m_owner]) begin
`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TMO) begin m_owner = -1; m_err = 1'b1; m_cnt = 0; end
`endif
      end
    end
  end

  // Stimulus helpers.
  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic idle();
    req_valid = 0; req_write = 0; req_lock = 0;
    req_addr = 0; req_byteen = 0; req_wdata = 0;
  endtask

  task automatic req(input int id, input logic w, input logic l, input logic [AW-1:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    req_valid[id] = 1'b1; req_write[id] = w; req_lock[id] = l;
    req_addr[id*AW +: AW] = a; req_byteen[4*id +: 4] = be; req_wdata[32*id +: 32] = d;
  endtask

  task automatic drop(input int id);
    req_valid[id] = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    idle();
    HRESETN = 0;
    repeat (3) tick();
    #2;
    chk("reset_gnt", req_gnt, 0);
    chk("reset_busy", busy, 0);
    HRESETN = 1;
    tick();

    // Full-word write then readback.
    req(0, 1, 0, 8'h10, 4'hF, 32'hDEADBEEF); #2 chk("wr_gnt", req_gnt, 2'b01);
    tick();
    req(0, 0, 0, 8'h10, 4'h0, 32'h0);       #2 chk("rd_gnt", req_gnt, 2'b01);
    tick(); idle();                          #2 chk("rd_mem_ren", mem_ren, 1);
    chk("rd_mem_addr", mem_addr, 8'h10);
    chk("rd_rvalid_early", rsp_rvalid, 0);
    tick();                                  #2 chk("rd_rvalid", rsp_rvalid, 2'b01);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();                                  #2 chk("rd_rvalid_done", rsp_rvalid, 0);

    // Round-robin from reset with both requesters reading every cycle.
    HRESETN = 0; tick(); HRESETN = 1; tick();
    req(0, 0, 0, 8'h10, 4'h0, 32'h0);
    req(1, 0, 0, 8'h20, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #2 chk($sformatf("alt_gnt%0d", k), req_gnt, (k % 2) ? 2 : 1);
      tick();
    end
    idle(); repeat (3) tick();

    // Lock by req 1: four locked beats plus the releasing beat, req 0 stalls.
    req(0, 0, 0, 8'h10, 4'h0, 32'h0);       #2 chk("lk_pre", req_gnt, 2'b01);
    tick();
    for (int k = 0; k < 5; k++) begin
      req(1, 1, (k < 4), 8'(8'h30 + k), 4'hF, 32'h100 + k);
      #2 chk($sformatf("lk_gnt%0d", k), req_gnt, 2'b10);
      tick();
    end
    drop(1);                                 #2 chk("lk_after", req_gnt, 2'b01);
    tick(); idle(); repeat (3) tick();
    req(0, 0, 0, 8'h32, 4'h0, 32'h0); tick(); idle(); tick();
    #2 chk("lk_data", rsp_rdata, 32'h102);

    // Byte-lane write.
    tick();
    req(0, 1, 0, 8'h40, 4'hF, 32'h11223344); tick();
    req(0, 1, 0, 8'h40, 4'b0010, 32'h0000AB00); tick();
    req(0, 0, 0, 8'h40, 4'h0, 32'h0); tick();
    idle(); tick();                          #2 chk("be_rvalid", rsp_rvalid, 2'b01);
    chk("be_rdata", rsp_rdata, 32'h1122AB44);
    tick();

    // Reset the cycle after a read accept: no response must appear.
    req(0, 0, 0, 8'h40, 4'h0, 32'h0);       #2 chk("rr_gnt", req_gnt, 2'b01);
    tick();
    #1 chk("rr_ren_before", mem_ren, 1);
    HRESETN = 0; idle();
    #1 chk("rr_ren_async", mem_ren, 0);
    chk("rr_busy", busy, 0);
    tick();                                  #2 chk("rr_rvalid", rsp_rvalid, 0);
    tick(); HRESETN = 1; tick();

    // Lock owner goes silent while req 1 waits.
    req(0, 1, 1, 8'h50, 4'hF, 32'h55); #2 chk("to_gnt", req_gnt, 2'b01);
    tick();
    drop(0);
    req(1, 0, 0, 8'h10, 4'h0, 32'h0);
    for (int k = 0; k < TMO; k++) begin
      if (k == 0 || k == TMO - 1) begin
        #2 chk($sformatf("to_stall%0d", k), req_gnt, 2'b00);
      end
      tick();
    end
    #2;
`ifdef SRAM_ARB_LOCK_TIMEOUT_EN
    chk("to_gnt_after", req_gnt, 2'b10);
    chk("to_lock_err", lock_err, 1);
    tick(); drop(1);
`else
    chk("to_gnt_after", req_gnt, 2'b00);
    chk("to_lock_err", lock_err, 0);
    tick();
    req(0, 1, 0, 8'h51, 4'hF, 32'h66);       #2 chk("to_release", req_gnt, 2'b01);
    tick(); drop(0);                         #2 chk("to_req1", req_gnt, 2'b10);
    tick(); drop(1);
`endif
    idle(); repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
